reg_bank_wr_arbiter: RTL and testbench

//  Shares one bank of NREG 32-bit dual-enable config registers among NREQ requesters
//  (run control, IPbus slave, trigger manager, ...). Round-robin arbitration; drives
//  per-register enable 1 (reg_sel) and common enable 2 (reg_wr_stb) so exactly one

---
 rtl/reg_bank_wr_arbiter_pkg.sv | 21 ++
 rtl/reg_bank_wr_arbiter_rr_arbiter.sv | 34 +++
 rtl/reg_bank_wr_arbiter.sv | 155 +++++++++++++++
 tb/tb_reg_bank_wr_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_wr_arbiter_pkg.sv
// Shared types and defaults for the register-bank write arbiter.
// Holds FSM state codes, default geometry and a saturating counter helper.
package reg_bank_wr_arbiter_pkg;

  localparam int unsigned DefNreq = 4;
  localparam int unsigned DefNreg = 8;
  localparam int unsigned DefAw   = 3;
  localparam int unsigned DataW   = 32;
  localparam int unsigned CountW  = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StWrite = 2'd2
  } state_e;

  function automatic logic [CountW-1:0] sat_inc(input logic [CountW-1:0] v);
    return (&v) ? v : v + CountW'(1);
  endfunction

endpackage

// File: rtl/reg_bank_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the pointer,
// wrapping from NREQ-1 back to 0.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  int unsigned w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = 32'(i_ptr) + k;
      if (w_cand >= NREQ) begin
        w_cand = w_cand - NREQ;
      end
      if (!o_valid && i_req[w_cand[IW-1:0]]) begin
        o_valid                = 1'b1;
        o_idx                  = w_cand[IW-1:0];
        o_gnt[w_cand[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bank_wr_arbiter.sv
// Round-robin write arbiter in front of a bank of dual-enable config registers:
// one granted write produces exactly one reg_sel/reg_wr_stb pulse.
module reg_bank_wr_arbiter
  import reg_bank_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned NREG = DefNreg,
  parameter int unsigned AW   = DefAw
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  freeze,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*DataW-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       req_err,
  output logic [DataW-1:0]      reg_wdata,
  output logic [NREG-1:0]       reg_sel,
  output logic                  reg_wr_stb,
  output logic                  busy,
  output logic [CountW-1:0]     wr_count
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e              r_state, w_state_d;
  logic [IW-1:0]       r_ptr, w_ptr_d;
  logic [IW-1:0]       r_win, w_win_d;
  logic [AW-1:0]       r_addr, w_addr_d;
  logic [DataW-1:0]    r_data, w_data_d;
  logic [DataW-1:0]    r_wdata, w_wdata_d;
  logic [NREG-1:0]     r_sel, w_sel_d;
  logic                r_stb, w_stb_d;
  logic [NREQ-1:0]     r_ready, w_ready_d;
  logic [NREQ-1:0]     r_err, w_err_d;
  logic                r_busy, w_busy_d;
  logic [CountW-1:0]   r_wr_count, w_wr_count_d;

  logic [AW-1:0]       w_req_addr [NREQ];
  logic [DataW-1:0]    w_req_data [NREQ];
  logic [NREQ-1:0]     w_arb_gnt;
  logic [IW-1:0]       w_arb_idx;
  logic                w_arb_valid;
  logic                w_addr_ok;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_req_addr[g] = req_addr[g*AW +: AW];
    assign w_req_data[g] = req_data[g*DataW +: DataW];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  // Out-of-range addresses complete with an error instead of touching the bank.
  assign w_addr_ok = (32'(r_addr) < NREG);

  always_comb begin
    w_state_d    = r_state;
    w_ptr_d      = r_ptr;
    w_win_d      = r_win;
    w_addr_d     = r_addr;
    w_data_d     = r_data;
    w_wdata_d    = r_wdata;
    w_sel_d      = '0;
    w_stb_d      = 1'b0;
    w_ready_d    = '0;
    w_err_d      = '0;
    w_busy_d     = 1'b0;
    w_wr_count_d = r_wr_count;
    unique case (r_state)
      StIdle: begin
        if (w_arb_valid && !freeze) begin
          w_state_d = StGrant;
          w_win_d   = w_arb_idx;
          w_addr_d  = w_req_addr[w_arb_idx];
          w_data_d  = w_req_data[w_arb_idx];
          w_busy_d  = 1'b1;
        end
      end
      StGrant: begin
        w_state_d        = StWrite;
        w_wdata_d        = r_data;
        w_busy_d         = 1'b1;
        w_ready_d[r_win] = 1'b1;
        if (w_addr_ok) begin
          w_sel_d = NREG'(1) << r_addr;
          w_stb_d = 1'b1;
        end else begin
          w_err_d[r_win] = 1'b1;
        end
      end
      StWrite: begin
        w_state_d = StIdle;
        if (32'(r_win) == NREQ - 1) begin
          w_ptr_d = '0;
        end else begin
          w_ptr_d = r_win + IW'(1);
        end
        if (w_addr_ok) begin
          w_wr_count_d = sat_inc(r_wr_count);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Asynchronous reset clears the enables at once, aborting any write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_ptr      <= '0;
      r_win      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_wdata    <= '0;
      r_sel      <= '0;
      r_stb      <= 1'b0;
      r_ready    <= '0;
      r_err      <= '0;
      r_busy     <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_state    <= w_state_d;
      r_ptr      <= w_ptr_d;
      r_win      <= w_win_d;
      r_addr     <= w_addr_d;
      r_data     <= w_data_d;
      r_wdata    <= w_wdata_d;
      r_sel      <= w_sel_d;
      r_stb      <= w_stb_d;
      r_ready    <= w_ready_d;
      r_err      <= w_err_d;
      r_busy     <= w_busy_d;
      r_wr_count <= w_wr_count_d;
    end
  end

  assign req_ready  = r_ready;
  assign req_err    = r_err;
  assign reg_wdata  = r_wdata;
  assign reg_sel    = r_sel;
  assign reg_wr_stb = r_stb;
  assign busy       = r_busy;
  assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Bench for reg_bank_wr_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level round-robin model.
module tb_reg_bank_wr_arbiter;

  localparam int NREQ = 4;
  localparam int NREG = 6;
  localparam int AW   = 3;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 freeze;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*32-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_err;
  logic [31:0]          reg_wdata;
  logic [NREG-1:0]      reg_sel;
  logic                 reg_wr_stb;
  logic                 busy;
  logic [15:0]          wr_count;

  int errors = 0;
  int checks = 0;

  // Expected outputs and model state
  logic [NREG-1:0] e_sel;
  logic            e_stb;
  logic            e_busy;
  logic [NREQ-1:0] e_ready;
  logic [NREQ-1:0] e_err;
  logic [31:0]     e_wdata;
  logic [15:0]     e_count;
  int              m_ptr;
  int              m_win;
  int              m_addr;
  logic [31:0]     m_data;
  bit              m_active;
  int              m_done_edge;
  int              n_edge = 0;

  logic [31:0]     bank [NREG];
  int              served [$];

  reg_bank_wr_arbiter #(
    .NREQ (NREQ),
    .NREG (NREG),
    .AW   (AW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .freeze     (freeze),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .req_err    (req_err),
    .reg_wdata  (reg_wdata),
    .reg_sel    (reg_sel),
    .reg_wr_stb (reg_wr_stb),
    .busy       (busy),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  // The register bank itself: a register loads when both its enables are high.
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (reg_wr_stb && reg_sel[i]) bank[i] <= reg_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_sel = '0; e_stb = 1'b0; e_busy = 1'b0; e_ready = '0; e_err = '0;
    e_wdata = '0; e_count = '0; m_ptr = 0; m_win = 0; m_active = 1'b0;
  endtask

  // One write = sample edge, then outputs for the cycle after the next edge, then retire.
  task automatic model_edge();
    bit found;
    int c;
    n_edge++;
    if (m_active && n_edge == m_done_edge) begin
      e_sel = '0; e_stb = 1'b0; e_ready = '0; e_err = '0; e_busy = 1'b0;
      m_ptr = (m_win + 1) % NREQ;
      if (m_addr < NREG && e_count != 16'hFFFF) e_count = e_count + 16'd1;
      m_active = 1'b0;
    end else if (m_active && n_edge == m_done_edge - 1) begin
      e_wdata = m_data;
      e_ready[m_win] = 1'b1;
      if (m_addr < NREG) begin
        e_sel = '0;
        e_sel[m_addr] = 1'b1;
        e_stb = 1'b1;
      end else begin
        e_err[m_win] = 1'b1;
      end
    end else if (!m_active && req_valid != '0 && !freeze) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (!found && req_valid[c]) begin
          found = 1'b1;
          m_win = c;
        end
      end
      m_addr = int'(req_addr[m_win*AW +: AW]);
      m_data = req_data[m_win*32 +: 32];
      m_active = 1'b1;
      m_done_edge = n_edge + 2;
      e_busy = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("reg_sel", 64'(reg_sel), 64'(e_sel));
    chk("reg_wr_stb", 64'(reg_wr_stb), 64'(e_stb));
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("req_err", 64'(req_err), 64'(e_err));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("reg_wdata", 64'(reg_wdata), 64'(e_wdata));
    chk("wr_count", 64'(wr_count), 64'(e_count));
  endtask

  // Requesters drop valid once the model says their write completed.
  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    check_all();
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) served.push_back(i);
      if (e_ready[i]) req_valid[i] = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_req(input int i, input int addr, input logic [31:0] data);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = AW'(addr);
    req_data[i*32 +: 32] = data;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    freeze = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    model_reset();
    @(negedge clk);
    check_all();
    reset_n = 1'b1;

    // Single write; winner's data changes after sampling must not matter
    set_req(0, 2, 32'hDEADBEEF);
    tick();
    req_data[31:0] = 32'h12345678;
    tick();
    chk("t1_sel", 64'(reg_sel), 64'h04);
    chk("t1_wdata", 64'(reg_wdata), 64'hDEADBEEF);
    chk("t1_ready", 64'(req_ready), 64'h1);
    run(2);
    chk("t1_bank2", 64'(bank[2]), 64'hDEADBEEF);
    chk("t1_count", 64'(wr_count), 64'd1);

    // All requesters at once after reset: order 0,1,2,3 twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      served.delete();
      for (int i = 0; i < NREQ; i++) set_req(i, i, $urandom);
      run(13);
      chk("t2_nserved", 64'(served.size()), 64'd4);
      for (int i = 0; i < served.size(); i++) chk("t2_order", 64'(served[i]), 64'(i));
    end
    chk("t2_count", 64'(wr_count), 64'd8);

    // Out-of-range address then a good one from the same requester
    set_req(1, 7, 32'hBAD0BAD0);
    run(2);
    chk("t3_err", 64'(req_err), 64'h2);
    chk("t3_ready", 64'(req_ready), 64'h2);
    chk("t3_nostb", 64'(reg_wr_stb), 64'h0);
    run(2);
    chk("t3_count_hold", 64'(wr_count), 64'd8);
    set_req(1, 0, 32'hA5A5A5A5);
    run(4);
    chk("t3_count_inc", 64'(wr_count), 64'd9);
    chk("t3_bank0", 64'(bank[0]), 64'hA5A5A5A5);

    // Freeze holds off a pending request
    freeze = 1'b1;
    set_req(2, 3, 32'h0F0F0F0F);
    run(10);
    chk("t4_frozen_busy", 64'(busy), 64'h0);
    freeze = 1'b0;
    served.delete();
    run(4);
    chk("t4_served", 64'(served.size()), 64'd1);
    chk("t4_bank3", 64'(bank[3]), 64'h0F0F0F0F);

    // Reset during WRITE of requester 3 (pointer is 3 here)
    set_req(1, 4, 32'h11111111);
    set_req(3, 5, 32'h33333333);
    run(2);
    chk("t5_stb_before", 64'(reg_wr_stb), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("t5_stb_async", 64'(reg_wr_stb), 64'h0);
    chk("t5_sel_async", 64'(reg_sel), 64'h0);
    chk("t5_ready_async", 64'(req_ready), 64'h0);
    model_reset();
    tick();
    reset_n = 1'b1;
    set_req(3, 5, 32'h33333333);
    served.delete();
    run(7);
    chk("t5_nserved", 64'(served.size()), 64'd2);
    if (served.size() == 2) begin
      chk("t5_first", 64'(served[0]), 64'd1);
      chk("t5_second", 64'(served[1]), 64'd3);
    end
    chk("t5_count", 64'(wr_count), 64'd2);

    // Counter saturation
    force dut.r_wr_count = 16'hFFFE;
    e_count = 16'hFFFE;
    tick();
    release dut.r_wr_count;
    set_req(0, 1, 32'h00000001);
    run(4);
    chk("t6_count_max", 64'(wr_count), 64'hFFFF);
    set_req(2, 1, 32'h00000002);
    run(4);
    chk("t6_count_sat", 64'(wr_count), 64'hFFFF);

    // Random traffic with occasional freeze and bad addresses
    do_reset();
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, $urandom_range(0, 7), $urandom);
      end
      freeze = ($urandom_range(0, 7) == 0);
      tick();
    end
    freeze = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
